matrix_alu: RTL and testbench

Memory-mapped 4×4 matrix ALU and bus responder at address window 0x2000–0x2FFF. The execution engine drives `address`, `nRead`, `nWrite` and `ExeDataOut`; this block latches operands, executes on a command write, and returns results on `MatrixDataOut`. It runs multiply, add, subtract, transpose and scale on 16-bit-element matrices packed in 256-bit words.

---
 rtl/matrix_alu_pkg.sv | 39 +++
 rtl/matrix_alu_if.sv | 23 ++
 rtl/matrix_row_mac.sv | 29 ++
 rtl/matrix_alu.sv | 130 +++++++++++++
 tb/tb_matrix_alu.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_alu_pkg.sv
// Shared constants, FSM state type and element access helpers for the
// memory-mapped 4x4 matrix ALU.
package matrix_alu_pkg;

    localparam int EW = 16;           // element width
    localparam int N  = 4;            // matrix dimension
    localparam int WW = N * N * EW;   // packed matrix word width

    // Address decode: window nibble, op group (address[7:4]), register (address[3:0])
    localparam logic [3:0] ALU_BASE     = 4'h2;
    localparam logic [3:0] OP_MUL       = 4'h0;
    localparam logic [3:0] OP_ADD       = 4'h1;
    localparam logic [3:0] OP_SUB       = 4'h2;
    localparam logic [3:0] OP_TRANSPOSE = 4'h3;
    localparam logic [3:0] OP_SCALE     = 4'h4;
    localparam logic [3:0] REG_SRCA     = 4'h0;
    localparam logic [3:0] REG_SRCB     = 4'h1;
    localparam logic [3:0] REG_RESULT   = 4'h2;
    localparam logic [3:0] REG_CMD      = 4'h3;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } alu_state_t;

    // Element (r,c) lives at bits [EW*(N*r+c) +: EW].
    function automatic logic [EW-1:0] elem_get(input logic [WW-1:0] m, input int r, input int c);
        return m[EW*(N*r+c) +: EW];
    endfunction

    function automatic logic [WW-1:0] elem_set(input logic [WW-1:0] m, input int r, input int c,
                                               input logic [EW-1:0] v);
        logic [WW-1:0] t;
        t = m;
        t[EW*(N*r+c) +: EW] = v;
        return t;
    endfunction

endpackage

// File: rtl/matrix_alu_if.sv
// Engine-to-matrix-ALU bus: address, strobes, write data, read data and status.
interface matrix_alu_if;
    import matrix_alu_pkg::*;

    logic [15:0]   address;
    logic          nRead;
    logic          nWrite;
    logic [WW-1:0] ExeDataOut;
    logic [WW-1:0] MatrixDataOut;
    logic          Busy;
    logic          Complete;

    modport master (
        output address, nRead, nWrite, ExeDataOut,
        input  MatrixDataOut, Busy, Complete
    );

    modport slave (
        input  address, nRead, nWrite, ExeDataOut,
        output MatrixDataOut, Busy, Complete
    );

endinterface

// File: rtl/matrix_row_mac.sv
// Combinational row multiply-accumulate: one result row of A*B, each element
// the low EW bits of the sum of N products.
module matrix_row_mac
    import matrix_alu_pkg::*;
(
    input  logic [WW-1:0]   src_a,
    input  logic [WW-1:0]   src_b,
    input  logic [1:0]      row,
    output logic [N*EW-1:0] row_out
);

    logic [EW-1:0] acc;

    // Dot product of srcA row `row` with every srcB column.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch or loop, so no path leaves it holding its old value (a latch).
        row_out = '0;
        acc     = '0;
        for (int c = 0; c < N; c++) begin
            acc = '0;
            for (int k = 0; k < N; k++) begin
                acc = acc + elem_get(src_a, int'(row), k) * elem_get(src_b, k, c);
            end
            row_out[EW*c +: EW] = acc;
        end
    end

endmodule

// File: rtl/matrix_alu.sv
// Memory-mapped 4x4 matrix ALU: bus decode, operand registers, command FSM,
// elementwise ops, row-serial multiply and registered read mux.
module matrix_alu
    import matrix_alu_pkg::*;
(
    input  logic         Clk,
    input  logic         nReset,
    matrix_alu_if.slave  bus
);

    localparam int ROW_W = N * EW;

    logic [WW-1:0]          srca, srcb, result, rd_data, ew_result;
    logic [(N-1)*ROW_W-1:0] mul_acc;   // rows 0..N-2 held until the last row lands
    logic [ROW_W-1:0]       row_out;
    logic [EW-1:0]          ew_val;
    logic [3:0]             op, reg_sel;
    logic [1:0]             row;
    logic                   busy, complete, cmd_q;
    logic                   selected, wr_sel, rd_sel, cmd_sel, cmd_accept;
    logic [3:0]             unused_addr;
    alu_state_t             state;

    assign selected    = (bus.address[15:12] == ALU_BASE);
    assign reg_sel     = bus.address[3:0];
    assign wr_sel      = selected && !bus.nWrite;
    assign rd_sel      = selected && !bus.nRead;
    assign cmd_sel     = wr_sel && (reg_sel == REG_CMD);
    // Accept only the first cycle of a command write, only when idle, only for defined ops.
    assign cmd_accept  = cmd_sel && !cmd_q && (state == IDLE) && (bus.address[7:4] <= OP_SCALE);
    assign unused_addr = bus.address[11:8];

    matrix_row_mac u_row_mac (
        .src_a   (srca),
        .src_b   (srcb),
        .row     (row),
        .row_out (row_out)
    );

    // Elementwise single-cycle ops selected by the latched op code.
    always_comb begin
        ew_result = '0;
        ew_val    = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (op)
                    OP_ADD:       ew_val = elem_get(srca, r, c) + elem_get(srcb, r, c);
                    OP_SUB:       ew_val = elem_get(srca, r, c) - elem_get(srcb, r, c);
                    OP_TRANSPOSE: ew_val = elem_get(srca, c, r);
                    OP_SCALE:     ew_val = elem_get(srca, r, c) * srcb[EW-1:0];
                    default:      ew_val = '0;
                endcase
                ew_result = elem_set(ew_result, r, c, ew_val);
            end
        end
    end

    // Bus side: operand writes (locked out while busy), read mux, command-select history.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            // NOTE: the wide operand/result registers are reset on purpose: a read
            // after reset must return zero, so they are not left as plain storage.
            srca    <= '0;
            srcb    <= '0;
            rd_data <= '0;
            cmd_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            cmd_q <= cmd_sel;
            if (wr_sel && (state == IDLE)) begin
                if (reg_sel == REG_SRCA)
                    srca <= bus.ExeDataOut;
                else if (reg_sel == REG_SRCB)
                    srcb <= bus.ExeDataOut;
            end
            rd_data <= '0;
            if (rd_sel && bus.nWrite) begin
                case (reg_sel)
                    REG_SRCA:   rd_data <= srca;
                    REG_SRCB:   rd_data <= srcb;
                    REG_RESULT: rd_data <= result;
                    default:    rd_data <= '0;
                endcase
            end
        end
    end

    // Command FSM: single-cycle ops finish in one EXEC cycle, MUL runs one row per cycle.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            op       <= OP_MUL;
            row      <= '0;
            busy     <= 1'b0;
            complete <= 1'b0;
            result   <= '0;
            mul_acc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        state    <= EXEC;
                        op       <= bus.address[7:4];
                        row      <= '0;
                        busy     <= 1'b1;
                        complete <= 1'b0;
                    end
                end
                EXEC: begin
                    if (op == OP_MUL && row != 2'(N-1)) begin
                        mul_acc[ROW_W*row +: ROW_W] <= row_out;
                        row                         <= row + 2'd1;
                    end else begin
                        result   <= (op == OP_MUL) ? {row_out, mul_acc} : ew_result;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        complete <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MatrixDataOut = rd_data;
    assign bus.Busy          = busy;
    assign bus.Complete      = complete;

endmodule

// File: tb/tb_matrix_alu.sv
// Scoreboard bench for matrix_alu: reads push their expected word into a queue,
// a monitor compares MatrixDataOut one edge later; status is checked inline.
module tb_matrix_alu;
    import matrix_alu_pkg::*;

    logic Clk = 1'b0;
    logic nReset = 1'b1;
    logic rd_seen;
    int   total = 0;
    int   bad = 0;

    logic [WW-1:0] exp_q[$];
    string         name_q[$];

    matrix_alu_if bus();

    matrix_alu dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] mat_fill(input logic [EW-1:0] v);
        logic [WW-1:0] m;
        for (int i = 0; i < N*N; i++) m[EW*i +: EW] = v;
        return m;
    endfunction

    // Element (r,c) = 4r+c, or 4c+r when tr is set.
    function automatic logic [WW-1:0] mat_seq(input bit tr);
        logic [WW-1:0] m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[EW*(N*r+c) +: EW] = tr ? EW'(N*c+r) : EW'(N*r+c);
        return m;
    endfunction

    function automatic logic [WW-1:0] mat_ident();
        logic [WW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[EW*(N*i+i) +: EW] = 16'h0001;
        return m;
    endfunction

    // Read strobe seen at an edge means MatrixDataOut holds a response afterwards.
    always @(posedge Clk or negedge nReset) begin
        if (!nReset) rd_seen <= 1'b0;
        else         rd_seen <= !bus.nRead;
    end

    always @(negedge Clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got %h with empty scoreboard", bus.MatrixDataOut);
            end else begin
                check(name_q.pop_front(), bus.MatrixDataOut, exp_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [15:0] addr, input logic [WW-1:0] data);
        bus.address = addr; bus.ExeDataOut = data; bus.nWrite = 1'b0;
        @(negedge Clk);
        bus.nWrite = 1'b1; bus.address = '0;
    endtask

    task automatic bus_cmd(input logic [15:0] addr);
        bus.address = addr; bus.nWrite = 1'b0;
        @(negedge Clk);
        bus.nWrite = 1'b1; bus.address = '0;
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [WW-1:0] exp, input string name);
        exp_q.push_back(exp); name_q.push_back(name);
        bus.address = addr; bus.nRead = 1'b0;
        @(negedge Clk);
        bus.nRead = 1'b1; bus.address = '0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!(bus.Complete && !bus.Busy) && n < max_cycles) begin
            @(negedge Clk);
            n++;
        end
        check(name, WW'(n < max_cycles), WW'(1));
    endtask

    initial begin
        int n;
        bus.address = '0; bus.nRead = 1'b1; bus.nWrite = 1'b1; bus.ExeDataOut = '0;
        #1 nReset = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_data", bus.MatrixDataOut, '0);
        check("rst_busy", WW'(bus.Busy), '0);
        check("rst_complete", WW'(bus.Complete), '0);
        nReset = 1'b1;
        @(negedge Clk);

        // ADD with wrap-around, command held two cycles
        bus_write(16'h2010, mat_fill(16'h0001));
        bus_write(16'h2011, mat_fill(16'hFFFF));
        bus.address = 16'h2013; bus.nWrite = 1'b0;
        @(negedge Clk);
        check("add_busy", WW'(bus.Busy), WW'(1));
        check("add_not_complete", WW'(bus.Complete), '0);
        @(negedge Clk);
        check("add_complete", WW'(bus.Complete), WW'(1));
        check("add_idle", WW'(bus.Busy), '0);
        bus.nWrite = 1'b1; bus.address = '0;
        @(negedge Clk);
        check("add_single_accept", WW'(bus.Busy), '0);
        bus_read(16'h2012, mat_fill(16'h0000), "add_result");
        bus_read(16'h2010, mat_fill(16'h0001), "add_srca");

        // MUL identity x sequence: busy exactly four cycles
        bus_write(16'h2000, mat_ident());
        bus_write(16'h2001, mat_seq(1'b0));
        bus_cmd(16'h2003);
        n = 0;
        while (bus.Busy && n < 10) begin
            n++;
            @(negedge Clk);
        end
        check("mul_busy_cycles", WW'(n), WW'(4));
        check("mul_complete", WW'(bus.Complete), WW'(1));
        bus_read(16'h2002, mat_seq(1'b0), "mul_ident_result");

        // MUL 0x0100 x 0x0100 wraps to zero; srcA write and ADD command issued while busy
        bus_write(16'h2000, mat_fill(16'h0100));
        bus_write(16'h2001, mat_fill(16'h0100));
        bus_cmd(16'h2003);
        bus_write(16'h2000, mat_ident());
        bus_cmd(16'h2013);
        check("lock_busy", WW'(bus.Busy), WW'(1));
        check("lock_not_complete", WW'(bus.Complete), '0);
        wait_done("lock_mul_done", 10);
        bus_read(16'h2002, mat_fill(16'h0000), "mul_wrap_result");
        bus_read(16'h2000, mat_fill(16'h0100), "lock_srca_kept");
        check("lock_no_add", WW'(bus.Busy), '0);

        // SUB, command held three cycles: must not re-trigger
        bus_write(16'h2000, mat_fill(16'h0005));
        bus_write(16'h2001, mat_fill(16'h0007));
        bus.address = 16'h2023; bus.nWrite = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("sub_complete", WW'(bus.Complete), WW'(1));
        @(negedge Clk);
        check("sub_held_no_retrigger", WW'(bus.Busy), '0);
        bus.nWrite = 1'b1; bus.address = '0;
        bus_read(16'h2012, mat_fill(16'hFFFE), "sub_result");

        // TRANSPOSE
        bus_write(16'h2000, mat_seq(1'b0));
        bus_cmd(16'h2033);
        wait_done("tr_done", 5);
        bus_read(16'h2002, mat_seq(1'b1), "transpose_result");

        // SCALE: only B[15:0] is the factor
        bus_write(16'h2000, mat_fill(16'h2000));
        bus_write(16'h2001, {mat_fill(16'h1234) >> EW, 16'h0003});
        bus_cmd(16'h2043);
        wait_done("scale_done", 5);
        bus_read(16'h2002, mat_fill(16'h6000), "scale_result");

        // Undefined op leaves status and result alone
        bus_cmd(16'h2053);
        @(negedge Clk);
        check("undef_busy", WW'(bus.Busy), '0);
        check("undef_complete", WW'(bus.Complete), WW'(1));
        bus_read(16'h2002, mat_fill(16'h6000), "undef_result");

        // Outside the window reads zero
        bus_read(16'h3012, '0, "unselected_read");

        // Read and write together: write lands, data out is zero
        exp_q.push_back('0); name_q.push_back("rw_data_zero");
        bus.address = 16'h2001; bus.ExeDataOut = mat_fill(16'hABCD);
        bus.nRead = 1'b0; bus.nWrite = 1'b0;
        @(negedge Clk);
        bus.nRead = 1'b1; bus.nWrite = 1'b1; bus.address = '0;
        bus_read(16'h2001, mat_fill(16'hABCD), "rw_write_landed");

        // Reset during MUL row 2
        bus_write(16'h2000, mat_ident());
        bus_write(16'h2001, mat_seq(1'b0));
        bus_cmd(16'h2003);
        @(negedge Clk);
        @(negedge Clk);
        check("midrst_busy_before", WW'(bus.Busy), WW'(1));
        nReset = 1'b0;
        #1;
        check("midrst_busy", WW'(bus.Busy), '0);
        check("midrst_complete", WW'(bus.Complete), '0);
        check("midrst_data", bus.MatrixDataOut, '0);
        @(negedge Clk);
        nReset = 1'b1;
        repeat (5) @(negedge Clk);
        check("midrst_stays_idle", WW'(bus.Complete), '0);
        bus_read(16'h2002, '0, "midrst_result");
        bus_read(16'h2000, '0, "midrst_srca");

        repeat (2) @(negedge Clk);
        check("scoreboard_drained", WW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
